// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and default widths for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

  localparam int unsigned c_ADDR_W = 32;
  localparam int unsigned c_INST_W = 32;
  localparam logic [c_ADDR_W-1:0] c_RESET_PC = '0;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Single-outstanding instruction fetch feeding the IF/ID buffer.
// Revision : 1.0
// ============================================================================
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = c_ADDR_W,
  parameter int unsigned INST_W   = c_INST_W,
  parameter int unsigned PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic [INST_W-1:0] r_hold_inst;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_pc;
  logic [INST_W-1:0] r_out_inst;
  logic              w_req_fire;

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign out_inst  = r_out_inst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_REQ;
      r_fetch_pc  <= RESET_PC;
      r_req_pc    <= '0;
      r_hold_inst <= '0;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_inst  <= '0;
    end else if (redirect_valid) begin
      // A redirect kills whatever is in flight; a request accepted this same
      // cycle still owes a response, so it must be drained before refetching.
      r_fetch_pc  <= redirect_pc;
      r_out_valid <= 1'b0;
      case (r_state)
        S_REQ:   r_state <= w_req_fire ? S_DRAIN : S_REQ;
        S_WAIT:  r_state <= imem_rsp_valid ? S_REQ : S_DRAIN;
        S_HOLD:  r_state <= S_REQ;
        S_DRAIN: r_state <= imem_rsp_valid ? S_REQ : S_DRAIN;
        default: r_state <= S_REQ;
      endcase
    end else begin
      if (!stall) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        S_REQ: begin
          if (w_req_fire) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (!stall) begin
              r_out_valid <= 1'b1;
              r_out_pc    <= r_req_pc;
              r_out_inst  <= imem_rsp_data;
              r_state     <= S_REQ;
            end else begin
              r_hold_inst <= imem_rsp_data;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_req_pc;
            r_out_inst  <= r_hold_inst;
            r_state     <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rsp_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Randomized bench for if_fetch_unit against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_b;

  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;

  logic        req_valid_b, req_ready_b;
  logic [31:0] req_addr_b;
  logic        rsp_valid_b;
  logic [31:0] rsp_data_b;
  logic        out_valid_b;
  logic [31:0] out_pc_b, out_inst_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  // Memory model state (single response slot, configurable latency)
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  // Transaction-level expectation of the fetch stage
  bit          m_outstanding, m_stale, m_held;
  logic [31:0] m_req_pc, m_hold_inst, m_next_fetch;
  bit          m_valid;
  logic [31:0] m_pc, m_inst;

  always #5 clk = ~clk;

  if_fetch_unit #(.ADDR_W(32), .INST_W(32), .PC_STEP(1), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst)
  );

  if_fetch_unit #(.ADDR_W(32), .INST_W(32), .PC_STEP(1), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n_b),
    .imem_req_valid(req_valid_b), .imem_req_ready(req_ready_b),
    .imem_req_addr(req_addr_b),
    .imem_rsp_valid(rsp_valid_b), .imem_rsp_data(rsp_data_b),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .stall(1'b0),
    .out_valid(out_valid_b), .out_pc(out_pc_b), .out_inst(out_inst_b)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic deliver(input logic [31:0] pc, input logic [31:0] inst);
    m_valid = 1'b1;
    m_pc    = pc;
    m_inst  = inst;
    n_deliv++;
  endtask

  // One clock of the main DUT: apply inputs, advance, update memory and model, compare.
  task automatic step(input bit rdy, input bit stl, input bit rdr,
                      input logic [31:0] rpc, input int lat);
    bit          hs, rsp;
    logic [31:0] rdata, acc_addr;
    rsp   = mem_busy && (mem_cnt == 0);
    rdata = mem_word(mem_addr);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? rdata : $urandom;
    imem_req_ready = rdy;
    stall          = stl;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    check_val("req_valid", imem_req_valid, !m_outstanding && !m_held);
    check_val("req_addr", imem_req_addr, m_next_fetch);
    hs       = imem_req_valid && rdy;
    acc_addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (rsp) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (hs) begin
      mem_busy = 1'b1;
      mem_addr = acc_addr;
      mem_cnt  = lat - 1;
    end
    if (rdr) begin
      m_next_fetch = rpc;
      m_valid      = 1'b0;
      m_held       = 1'b0;
      if (m_outstanding && rsp) begin
        m_outstanding = 1'b0;
        m_stale       = 1'b0;
      end else if (m_outstanding) begin
        m_stale = 1'b1;
      end
      if (hs) begin
        m_outstanding = 1'b1;
        m_stale       = 1'b1;
      end
    end else begin
      if (!stl) m_valid = 1'b0;
      if (hs) begin
        m_outstanding = 1'b1;
        m_stale       = 1'b0;
        m_req_pc      = m_next_fetch;
        m_next_fetch  = m_next_fetch + 32'd1;
      end else if (m_outstanding && rsp) begin
        m_outstanding = 1'b0;
        if (m_stale) m_stale = 1'b0;
        else if (!stl) deliver(m_req_pc, rdata);
        else begin
          m_held      = 1'b1;
          m_hold_inst = rdata;
        end
      end else if (m_held && !stl) begin
        m_held = 1'b0;
        deliver(m_req_pc, m_hold_inst);
      end
    end
    check_val("out_valid", out_valid, m_valid);
    check_val("out_pc", out_pc, m_pc);
    check_val("out_inst", out_inst, m_inst);
    if (out_valid) check_val("inst_of_pc", out_inst, mem_word(out_pc));
  endtask

  task automatic step_b(input bit rdy, input bit rsp, input logic [31:0] data);
    req_ready_b = rdy;
    rsp_valid_b = rsp;
    rsp_data_b  = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    redirect_valid = 0; redirect_pc = '0; stall = 0;
    req_ready_b = 0; rsp_valid_b = 0; rsp_data_b = '0;
    m_outstanding = 0; m_stale = 0; m_held = 0;
    m_req_pc = '0; m_hold_inst = '0; m_next_fetch = 32'h0;
    m_valid = 0; m_pc = '0; m_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_pc", out_pc, 32'h0);
    check_val("rst_out_inst", out_inst, 32'h0);
    check_val("rst_req_valid", imem_req_valid, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Memory not ready: address parks at 0, nothing delivered
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1);
      check_val("nrdy_addr", imem_req_addr, 32'h0);
      check_val("nrdy_valid", out_valid, 1'b0);
    end

    // Back-to-back stream: one instruction every second cycle
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1);
      check_val("stream_valid", out_valid, (i % 2) == 0);
      if (i % 2 == 0) check_val("stream_pc", out_pc, 32'(i / 2 - 1));
    end

    // Response for pc 4 lands under a 3-cycle stall
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_val("hold_pc", out_pc, 32'd3);
    check_val("hold_reqv", imem_req_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    check_val("unstall_pc", out_pc, 32'd4);
    check_val("unstall_valid", out_valid, 1'b1);

    // Redirect while pc 5 is outstanding
    step(1'b1, 1'b0, 1'b0, 32'h0, 2);
    step(1'b1, 1'b0, 1'b1, 32'h40, 1);
    check_val("rdw_valid", out_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    check_val("drain_valid", out_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    check_val("rdw_target", out_pc, 32'h40);

    // Redirect coinciding with the response
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    step(1'b1, 1'b0, 1'b1, 32'h80, 1);
    check_val("rdr_rsp_valid", out_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    check_val("rdr_rsp_target", out_pc, 32'h80);

    // Redirect while holding under stall clears out_valid anyway
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_val("stall_held_valid", out_valid, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'hC0, 1);
    check_val("rdr_stall_valid", out_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1);
    check_val("rdr_hold_target", out_pc, 32'hC0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
           $urandom, int'($urandom_range(1, 3)));
    end
    check_val("progress", n_deliv > 40, 1'b1);

    // Wrap instance: RESET_PC = all ones
    @(negedge clk);
    rst_n_b = 1'b1;
    @(posedge clk);
    #1;
    check_val("b_addr0", req_addr_b, 32'hFFFF_FFFF);
    step_b(1'b1, 1'b0, 32'h0);
    step_b(1'b1, 1'b1, mem_word(32'hFFFF_FFFF));
    check_val("b_pc_max", out_pc_b, 32'hFFFF_FFFF);
    check_val("b_valid_max", out_valid_b, 1'b1);
    check_val("b_addr_wrap", req_addr_b, 32'h0);
    step_b(1'b1, 1'b0, 32'h0);
    step_b(1'b1, 1'b1, mem_word(32'h0));
    check_val("b_pc_wrap", out_pc_b, 32'h0);
    step_b(1'b1, 1'b0, 32'h0);
    rst_n_b = 1'b0;
    #1;
    check_val("b_rst_valid", out_valid_b, 1'b0);
    check_val("b_rst_pc", out_pc_b, 32'h0);
    check_val("b_rst_inst", out_inst_b, 32'h0);
    check_val("b_rst_addr", req_addr_b, 32'hFFFF_FFFF);
    @(negedge clk);
    rst_n_b = 1'b1;
    step_b(1'b0, 1'b1, 32'hDEAD_BEEF);
    check_val("b_late_valid", out_valid_b, 1'b0);
    check_val("b_late_reqv", req_valid_b, 1'b1);
    step_b(1'b1, 1'b0, 32'h0);
    step_b(1'b1, 1'b1, mem_word(32'hFFFF_FFFF));
    check_val("b_refetch_pc", out_pc_b, 32'hFFFF_FFFF);
    check_val("b_refetch_inst", out_inst_b, mem_word(32'hFFFF_FFFF));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage: owns the fetch PC and issues single-outstanding requests to instruction memory over a valid/ready request channel and a valid response channel.
- Presents fetched (pc, inst, valid) to the IF/ID pipeline buffer; it is the producer of that buffer's inputs.
- Honours downstream stall and branch/jump redirect from later stages.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- INST_W, 32, instruction width.
- PC_STEP, 1, PC increment per fetch; memory is word-addressed.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  request address, always equals fetch_pc.
- imem_rsp_valid  in  1  instruction data valid, one per accepted request, latency ≥1 cycle.
- imem_rsp_data  in  INST_W  instruction word.
- redirect_valid  in  1  load new fetch PC (taken branch/jump).
- redirect_pc  in  ADDR_W  redirect target.
- stall  in  1  downstream cannot accept; outputs must hold.
- out_valid  out  1  out_pc/out_inst carry a real instruction (0 = bubble).
- out_pc  out  ADDR_W  PC of delivered instruction.
- out_inst  out  INST_W  delivered instruction.

Behaviour:
- Reset (async assert, sync release): state=S_REQ, fetch_pc=RESET_PC, req_pc=0, hold_inst=0, out_valid=0, out_pc=0, out_inst=0.
- All outputs registered except imem_req_valid (decoded from state) and imem_req_addr (=fetch_pc).
- States: S_REQ, S_WAIT, S_HOLD, S_DRAIN.
- S_REQ: imem_req_valid=1. On valid&&ready: req_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP (mod 2^ADDR_W), go S_WAIT.
- S_WAIT: imem_req_valid=0. On rsp_valid: if !stall, out_valid<=1, out_pc<=req_pc, out_inst<=rsp_data, go S_REQ; if stall, hold_inst<=rsp_data, go S_HOLD.
- S_HOLD: imem_req_valid=0. When !stall: out_valid<=1, out_pc<=req_pc, out_inst<=hold_inst, go S_REQ.
- S_DRAIN: imem_req_valid=0. On rsp_valid, data discarded, go S_REQ.
- Output update: when stall=1, out_* hold. When stall=0 and no delivery this cycle, out_valid<=0; out_pc/out_inst hold.
- Redirect takes priority over stall and every state transition:
  - fetch_pc<=redirect_pc; out_valid<=0 even if stall=1.
  - S_REQ without handshake: stay S_REQ.
  - S_REQ with handshake same cycle: request is stale, go S_DRAIN.
  - S_WAIT without rsp: go S_DRAIN.
  - S_WAIT with rsp same cycle: response dropped, go S_REQ.
  - S_HOLD: held instruction dropped, go S_REQ.
  - S_DRAIN: stay S_DRAIN; a rsp in the same cycle is still consumed and the unit goes S_REQ.
- imem_rsp_valid is ignored in S_REQ and S_HOLD, including a stale response arriving after reset.
- Peak throughput: 1 instruction per 2 cycles with 1-cycle memory latency. Only one request is ever outstanding.
- Reset mid-operation clears all state immediately. The memory is required to share rst_n.

Decomposition:
- Package fetch_pkg holds the state enum (S_REQ=0, S_WAIT=1, S_HOLD=2, S_DRAIN=3), the ADDR_W/INST_W defaults and RESET_PC.
- No sub-module: the next-state logic, PC register and hold register stay inline.
- Bench memory model (imem_model, configurable latency and ready pattern) lives in the testbench only.

Test Plan:
- Reset, ready=1, latency 1, mem[i]=0xA000_0000+i: out sequence (0,0xA0000000),(1,0xA0000001),(2,…); out_valid pulses every 2nd cycle.
- Hold imem_req_ready=0 for 3 cycles: imem_req_addr stays 0, no out_valid; ready=1 -> fetch of addr 0 proceeds normally.
- Response for pc=4 arrives with stall=1 for 3 cycles: out_* hold previous values; state S_HOLD; stall drops -> next cycle out_pc=4, out_valid=1.
- redirect_valid with redirect_pc=0x40 while in S_WAIT (pc=5 outstanding): pc 5 response discarded; next delivered out_pc=0x40; out_valid=0 in between.
- Redirect on the same cycle as the response, and redirect while stall=1 in S_HOLD: both instructions dropped, out_valid=0 despite stall, next delivered out_pc=redirect_pc.
- RESET_PC=32'hFFFF_FFFF, PC_STEP=1: out_pc 0xFFFFFFFF then 0x00000000 (wrap); assert rst_n in S_WAIT -> outputs 0 immediately, late rsp ignored.
